// File: rtl/ecg_qrs_detector.sv
// ecg_qrs_detector
// Pan-Tompkins-style QRS detector placed after the ECG bandpass FIR.
// Processing chain: saturate to 16 bits -> five-point derivative -> square ->
// moving-window integration (MWI) -> threshold / refractory state machine.
// One pulse is emitted per detected QRS complex. It carries the peak MWI value
// and the sample index of that peak.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-high
//   din        signed FIR output sample (DIN_W bits)
//   din_valid  din carries a new sample this cycle
//   thresh     unsigned detection threshold, sampled live at each MWI evaluation
//   mwi_out    MWI result (window mean of squared derivative)
//   mwi_valid  one-cycle strobe, mwi_out valid (3 cycles after din_valid)
//   qrs_valid  one-cycle detection strobe
//   qrs_peak   peak MWI value of the last detected complex (held)
//   qrs_idx    sample index of that peak (held)
module ecg_qrs_detector #(
    parameter int DIN_W       = 59,
    parameter int MWI_LEN     = 32,
    parameter int REFRACT_LEN = 50,
    parameter int MAX_ABOVE   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DIN_W-1:0] din,
    input  logic                    din_valid,
    input  logic [31:0]             thresh,
    output logic [31:0]             mwi_out,
    output logic                    mwi_valid,
    output logic                    qrs_valid,
    output logic [31:0]             qrs_peak,
    output logic [31:0]             qrs_idx
);

    localparam int LOG_LEN = $clog2(MWI_LEN);
    localparam int SUM_W   = 32 + LOG_LEN;
    localparam int ACNT_W  = $clog2(MAX_ABOVE + 1);
    localparam int RCNT_W  = $clog2(REFRACT_LEN + 1);

    function automatic logic signed [15:0] sat16(input logic signed [DIN_W-1:0] v);
        logic signed [DIN_W-1:0] hi;
        logic signed [DIN_W-1:0] lo;
        hi = DIN_W'(32767);
        lo = DIN_W'(-32768);
        if (v > hi)      return 16'sh7fff;
        else if (v < lo) return 16'sh8000;
        else             return v[15:0];
    endfunction

    // Derivative is evaluated at 19 bits. The floor shift keeps the result
    // within 16 bits for any saturated input.
    function automatic logic signed [15:0] deriv5(input logic signed [15:0] x0,
                                                  input logic signed [15:0] x1,
                                                  input logic signed [15:0] x3,
                                                  input logic signed [15:0] x4);
        logic signed [18:0] acc;
        acc = (19'(x0) <<< 1) + 19'(x1) - 19'(x3) - (19'(x4) <<< 1);
        acc = acc >>> 3;
        return acc[15:0];
    endfunction

    // ---- stage 0: saturate, derivative, index tagging ----
    logic signed [15:0] x_sat;
    logic signed [15:0] xd [4];     // xd[k] holds x[n-1-k]
    logic [31:0]        idx_cnt;
    logic signed [15:0] d_p0;
    logic [31:0]        idx_p0;
    logic               vld_p0;

    assign x_sat = sat16(din);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) xd[i] <= '0;
            idx_cnt <= '0;
            d_p0    <= '0;
            idx_p0  <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= din_valid;
            if (din_valid) begin
                d_p0    <= deriv5(x_sat, xd[0], xd[2], xd[3]);
                xd[0]   <= x_sat;
                xd[1]   <= xd[0];
                xd[2]   <= xd[1];
                xd[3]   <= xd[2];
                idx_p0  <= idx_cnt;
                idx_cnt <= idx_cnt + 32'd1;
            end
        end
    end

    // ---- stage 1: square ----
    logic signed [31:0] sq_full;
    logic [31:0]        s_p1;
    logic [31:0]        idx_p1;
    logic               vld_p1;

    assign sq_full = d_p0 * d_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_p1   <= '0;
            idx_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                s_p1   <= sq_full;
                idx_p1 <= idx_p0;
            end
        end
    end

    // ---- stage 2: moving-window integration ----
    logic [31:0]        ring [MWI_LEN];
    logic [LOG_LEN-1:0] wptr;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   sum_next;
    logic [31:0]        idx_p2;

    // Running sum: add the newest square, drop the one leaving the window.
    assign sum_next = sum + SUM_W'(s_p1) - SUM_W'(ring[wptr]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MWI_LEN; i++) ring[i] <= '0;
            wptr      <= '0;
            sum       <= '0;
            mwi_out   <= '0;
            mwi_valid <= 1'b0;
            idx_p2    <= '0;
        end else begin
            mwi_valid <= vld_p1;
            if (vld_p1) begin
                ring[wptr] <= s_p1;
                wptr       <= wptr + 1'b1;
                sum        <= sum_next;
                mwi_out    <= sum_next[SUM_W-1:LOG_LEN];
                idx_p2     <= idx_p1;
            end
        end
    end

    // ---- stage 3: threshold / refractory decision ----
    typedef enum logic [1:0] {SEARCH, ABOVE, REFRACT} state_t;
    state_t            state;
    state_t            state_nxt;
    logic [ACNT_W-1:0] acnt;
    logic [RCNT_W-1:0] rcnt;
    logic [31:0]       peak;
    logic [31:0]       pidx;
    logic              above_thr;
    logic              detect;
    logic [31:0]       peak_fin;
    logic [31:0]       pidx_fin;

    assign above_thr = (mwi_out > thresh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEARCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mwi_valid) begin
            case (state)
                SEARCH:  if (above_thr) state_nxt = ABOVE;
                ABOVE:   if (!above_thr || acnt == ACNT_W'(MAX_ABOVE - 1)) state_nxt = REFRACT;
                REFRACT: if (rcnt == RCNT_W'(1)) state_nxt = SEARCH;
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // The timeout detect reports the peak including the current sample.
    always_comb begin
        detect   = mwi_valid && (state == ABOVE) &&
                   (!above_thr || acnt == ACNT_W'(MAX_ABOVE - 1));
        peak_fin = peak;
        pidx_fin = pidx;
        if (above_thr && mwi_out > peak) begin
            peak_fin = mwi_out;
            pidx_fin = idx_p2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acnt      <= '0;
            rcnt      <= '0;
            peak      <= '0;
            pidx      <= '0;
            qrs_valid <= 1'b0;
            qrs_peak  <= '0;
            qrs_idx   <= '0;
        end else begin
            qrs_valid <= detect;
            if (detect) begin
                qrs_peak <= peak_fin;
                qrs_idx  <= pidx_fin;
            end
            if (mwi_valid) begin
                case (state)
                    SEARCH: begin
                        if (above_thr) begin
                            peak <= mwi_out;
                            pidx <= idx_p2;
                            acnt <= ACNT_W'(1);
                        end
                    end
                    ABOVE: begin
                        peak <= peak_fin;
                        pidx <= pidx_fin;
                        acnt <= acnt + 1'b1;
                        if (detect) rcnt <= RCNT_W'(REFRACT_LEN);
                    end
                    REFRACT: rcnt <= rcnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ecg_qrs_detector.sv
module tb_ecg_qrs_detector;

    localparam int DIN_W       = 59;
    localparam int MWI_LEN     = 32;
    localparam int REFRACT_LEN = 50;
    localparam int MAX_ABOVE   = 64;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic signed [DIN_W-1:0] din = '0;
    logic                    din_valid = 1'b0;
    logic [31:0]             thresh = 32'hFFFF_FFFF;
    logic [31:0]             mwi_out;
    logic                    mwi_valid;
    logic                    qrs_valid;
    logic [31:0]             qrs_peak;
    logic [31:0]             qrs_idx;

    ecg_qrs_detector #(
        .DIN_W(DIN_W), .MWI_LEN(MWI_LEN), .REFRACT_LEN(REFRACT_LEN), .MAX_ABOVE(MAX_ABOVE)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .thresh(thresh),
        .mwi_out(mwi_out), .mwi_valid(mwi_valid), .qrs_valid(qrs_valid),
        .qrs_peak(qrs_peak), .qrs_idx(qrs_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint val;
        longint idx;
        int     cyc;
    } exp_t;

    exp_t   mq[$];
    exp_t   qq[$];
    longint cap_mwi[$];
    longint cap_qp[$];
    longint cap_qi[$];
    int     nchecks = 0;
    int     nerr = 0;

    function automatic void chk(string name, bit ok, longint act, longint exp);
        nchecks++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference model: straight from the arithmetic definition
    longint xh[5];
    longint sq[$];
    longint m_idx;
    int     m_state;   // 0 searching, 1 above threshold, 2 refractory
    longint m_peak;
    longint m_pidx;
    int     m_acnt;
    int     m_rcnt;

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) xh[i] = 0;
        sq.delete();
        m_idx = 0; m_state = 0; m_peak = 0; m_pidx = 0; m_acnt = 0; m_rcnt = 0;
    endfunction

    function automatic void model_emit(int c);
        exp_t e;
        e.val = m_peak; e.idx = m_pidx; e.cyc = c;
        qq.push_back(e);
    endfunction

    function automatic void model_step(longint v, int c);
        longint x, num, d, sum, m, t;
        exp_t   e;
        x = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
        for (int i = 4; i > 0; i--) xh[i] = xh[i-1];
        xh[0] = x;
        num = 2 * xh[0] + xh[1] - xh[3] - 2 * xh[4];
        d = (num >= 0) ? num / 8 : -((-num + 7) / 8);
        sq.push_back(d * d);
        if (sq.size() > MWI_LEN) void'(sq.pop_front());
        sum = 0;
        foreach (sq[i]) sum += sq[i];
        m = sum / MWI_LEN;
        e.val = m; e.idx = m_idx; e.cyc = c + 3;
        mq.push_back(e);
        t = longint'({32'd0, thresh});
        if (m_state == 0) begin
            if (m > t) begin
                m_state = 1; m_peak = m; m_pidx = m_idx; m_acnt = 1;
            end
        end else if (m_state == 1) begin
            if (m <= t) begin
                model_emit(c + 4);
                m_state = 2; m_rcnt = REFRACT_LEN;
            end else begin
                if (m > m_peak) begin
                    m_peak = m; m_pidx = m_idx;
                end
                m_acnt++;
                if (m_acnt == MAX_ABOVE) begin
                    model_emit(c + 4);
                    m_state = 2; m_rcnt = REFRACT_LEN;
                end
            end
        end else begin
            m_rcnt--;
            if (m_rcnt == 0) m_state = 0;
        end
        m_idx = (m_idx + 1) & 64'hFFFF_FFFF;
    endfunction

    // Monitor: pops expectations whenever the DUT strobes
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mwi_valid) begin
                cap_mwi.push_back(longint'(mwi_out));
                if (mq.size() == 0) chk("mwi_extra", 1'b0, longint'(mwi_out), 0);
                else begin
                    e = mq.pop_front();
                    chk("mwi_val", longint'(mwi_out) == e.val, longint'(mwi_out), e.val);
                    chk("mwi_lat", cyc == e.cyc, cyc, e.cyc);
                end
            end
            while (mq.size() > 0 && mq[0].cyc < cyc) begin
                chk("mwi_missing", 1'b0, cyc, mq[0].cyc);
                void'(mq.pop_front());
            end
            if (qrs_valid) begin
                cap_qp.push_back(longint'(qrs_peak));
                cap_qi.push_back(longint'(qrs_idx));
                if (qq.size() == 0) chk("qrs_extra", 1'b0, longint'(qrs_idx), 0);
                else begin
                    e = qq.pop_front();
                    chk("qrs_peak", longint'(qrs_peak) == e.val, longint'(qrs_peak), e.val);
                    chk("qrs_idx", longint'(qrs_idx) == e.idx, longint'(qrs_idx), e.idx);
                    chk("qrs_lat", cyc == e.cyc, cyc, e.cyc);
                end
            end
            while (qq.size() > 0 && qq[0].cyc < cyc) begin
                chk("qrs_missing", 1'b0, cyc, qq[0].cyc);
                void'(qq.pop_front());
            end
        end
    end

    task automatic feed(input longint v, input int gap);
        @(posedge clk); #1;
        din = DIN_W'(v);
        din_valid = 1'b1;
        model_step(v, cyc);
        repeat (gap) begin
            @(posedge clk); #1;
            din_valid = 1'b0;
            din = DIN_W'(longint'({$urandom(), $urandom()}));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            din_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        din_valid = 1'b0;
        #1;
        chk("rst_mwi_out", mwi_out == 0, longint'(mwi_out), 0);
        chk("rst_mwi_valid", mwi_valid == 0, longint'(mwi_valid), 0);
        chk("rst_qrs_valid", qrs_valid == 0, longint'(qrs_valid), 0);
        chk("rst_qrs_peak", qrs_peak == 0, longint'(qrs_peak), 0);
        chk("rst_qrs_idx", qrs_idx == 0, longint'(qrs_idx), 0);
        mq.delete();
        qq.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cap_mwi.delete(); cap_qp.delete(); cap_qi.delete();
    endtask

    task automatic step_seq(input int gap);
        repeat (100) feed(0, gap);
        repeat (53) feed(800, gap);
        repeat (93) feed(1600, gap);
        repeat (50) feed(2400, gap);
        repeat (40) feed(0, gap);
        idle(10);
    endtask

    longint ref_mwi[$];
    longint ref_qp[$];
    longint ref_qi[$];

    initial begin
        int bad;
        model_reset();

        // Saturation
        do_reset();
        thresh = 32'hFFFF_FFFF;
        feed(100000, 0);
        feed(-100000, 0);
        repeat (4) feed(0, 0);
        idle(8);
        chk("sat_count", cap_mwi.size() == 6, cap_mwi.size(), 6);
        if (cap_mwi.size() >= 2) begin
            chk("sat_pos", cap_mwi[0] == 2096640, cap_mwi[0], 2096640);
            chk("sat_neg", cap_mwi[1] == 2621184, cap_mwi[1], 2621184);
        end

        // Step and refractory
        do_reset();
        thresh = 32'd5000;
        step_seq(0);
        chk("step_mwi_count", cap_mwi.size() == 336, cap_mwi.size(), 336);
        if (cap_mwi.size() >= 104) begin
            chk("step_mwi_n0", cap_mwi[100] == 1250, cap_mwi[100], 1250);
            chk("step_mwi_n1", cap_mwi[101] == 4062, cap_mwi[101], 4062);
            chk("step_mwi_n2", cap_mwi[102] == 6875, cap_mwi[102], 6875);
            chk("step_mwi_n3", cap_mwi[103] == 8125, cap_mwi[103], 8125);
        end
        chk("step_qrs_count", cap_qi.size() >= 3, cap_qi.size(), 3);
        if (cap_qi.size() >= 3) begin
            chk("step_qrs_peak", cap_qp[0] == 8125, cap_qp[0], 8125);
            chk("step_qrs_idx", cap_qi[0] == 103, cap_qi[0], 103);
            chk("refract_idx", cap_qi[1] == 184, cap_qi[1], 184);
            chk("rearm_idx", cap_qi[2] == 249, cap_qi[2], 249);
        end
        ref_mwi = cap_mwi; ref_qp = cap_qp; ref_qi = cap_qi;

        // Same step with gaps between valid samples
        do_reset();
        step_seq(2);
        chk("gap_mwi_count", cap_mwi.size() == ref_mwi.size(), cap_mwi.size(), ref_mwi.size());
        bad = 0;
        foreach (ref_mwi[i]) if (i >= cap_mwi.size() || cap_mwi[i] != ref_mwi[i]) bad++;
        chk("gap_mwi_seq", bad == 0, bad, 0);
        chk("gap_qrs_count", cap_qi.size() == ref_qi.size(), cap_qi.size(), ref_qi.size());
        bad = 0;
        foreach (ref_qi[i])
            if (i >= cap_qi.size() || cap_qi[i] != ref_qi[i] || cap_qp[i] != ref_qp[i]) bad++;
        chk("gap_qrs_seq", bad == 0, bad, 0);

        // Reset in the middle of a complex, samples still in flight
        repeat (60) feed(0, 0);
        repeat (8) feed(800, 0);
        do_reset();
        step_seq(1);
        if (cap_qi.size() >= 1) chk("post_reset_idx", cap_qi[0] == 103, cap_qi[0], 103);
        else chk("post_reset_qrs", 1'b0, 0, 1);

        // Timeout on a steady ramp
        do_reset();
        thresh = 32'd5000;
        for (int n = 0; n < 320; n++) feed(100 * n, 0);
        idle(10);
        chk("timeout_count", cap_qi.size() == 3, cap_qi.size(), 3);
        bad = 0;
        foreach (cap_qp[i]) if (cap_qp[i] != 15625) bad++;
        chk("timeout_peak", bad == 0, bad, 0);
        if (cap_qi.size() >= 2) begin
            chk("timeout_idx0", cap_qi[0] == 35, cap_qi[0], 35);
            chk("timeout_idx1", cap_qi[1] == 127, cap_qi[1], 127);
        end

        // Randomized traffic, threshold changed between bursts
        do_reset();
        for (int r = 0; r < 6; r++) begin
            thresh = $urandom_range(0, 4000000);
            for (int k = 0; k < 150; k++) begin
                longint v;
                case ($urandom_range(0, 3))
                    0: v = longint'($urandom_range(0, 4000)) - 2000;
                    1: v = longint'($urandom_range(0, 80000)) - 40000;
                    2: v = longint'({$urandom(), $urandom()}) >>> 5;
                    default: v = 0;
                endcase
                feed(v, $urandom_range(0, 2));
            end
            idle(8);
        end

        idle(12);
        chk("mwi_queue_empty", mq.size() == 0, mq.size(), 0);
        chk("qrs_queue_empty", qq.size() == 0, qq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ecg_qrs_detector.md
# ecg_qrs_detector

Pan-Tompkins-style QRS detector sitting directly downstream of the ECG bandpass FIR. It accepts the FIR output sample stream and saturates it to 16 bits. It then runs five-point derivative, squaring and moving-window integration (MWI) stages, and a threshold/refractory state machine. For each detected QRS complex it emits one pulse carrying the peak MWI value and the sample index of that peak.

## Interface
- DIN_W, 59: width of signed input sample (FIR output width).
- MWI_LEN, 32: MWI window length in samples; power of two, 2..256.
- REFRACT_LEN, 50: refractory length in accepted MWI samples after each detection.
- MAX_ABOVE, 64: maximum MWI samples spent in ABOVE before a forced detection.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- din  in  DIN_W  signed filtered ECG sample.
- din_valid  in  1  din is a new sample this cycle.
- thresh  in  32  unsigned detection threshold, used live.
- mwi_out  out  32  unsigned MWI result.
- mwi_valid  out  1  one-cycle strobe, mwi_out valid.
- qrs_valid  out  1  one-cycle detection strobe.
- qrs_peak  out  32  peak MWI value of detected complex.
- qrs_idx  out  32  sample index of that peak.

## Operation
- Sample index: a 32-bit counter starting at 0 after reset, incremented per accepted din_valid, wraps 2^32-1 -> 0. The index travels with its sample through the pipeline.
- Saturate: x = din clamped to [-32768, 32767] (16-bit signed).
- Derivative: 4-deep delay line of x, zero after reset.
  - d = (2x[n] + x[n-1] - x[n-3] - 2x[n-4]) >>> 3, arithmetic shift (floor), computed at 19 bits.
  - d fits in 16-bit signed by construction.
- Square: s = d*d, 32-bit unsigned.
- MWI: ring buffer of MWI_LEN s values (zero after reset).
  - sum += s[n] - s[n-MWI_LEN], width 32+log2(MWI_LEN).
  - mwi_out = sum >> log2(MWI_LEN).
- All stages advance only on valid samples; no stalls, no backpressure.
- FSM, evaluated only on mwi_valid:
  - SEARCH: if mwi > thresh, go to ABOVE with peak=mwi, pidx=its index, acnt=1.
  - ABOVE, when mwi <= thresh: detect, then REFRACT with rcnt=REFRACT_LEN.
  - ABOVE, otherwise: if mwi > peak (strictly), update peak and pidx. Then acnt++. If acnt reaches MAX_ABOVE, detect, then REFRACT.
  - REFRACT: rcnt-- per mwi_valid. When rcnt reaches 0, go to SEARCH. The MWI sample that decrements rcnt to 0 is not compared against thresh.
  - Detect: register qrs_peak=peak and qrs_idx=pidx, and pulse qrs_valid.
- qrs_peak/qrs_idx hold their values until the next detection.

## Timing
- din_valid sampled high in cycle t produces mwi_valid high in cycle t+3, for exactly one cycle. Back-to-back din_valid yields back-to-back mwi_valid.
- qrs_valid rises in the cycle after the mwi_valid that triggers the detection.
- Reset values:
  - mwi_out=0, mwi_valid=0, qrs_valid=0, qrs_peak=0, qrs_idx=0.
  - State SEARCH, all counters, delay lines, ring buffer and sum cleared.
- Reset mid-operation discards in-flight samples; no strobe is produced for them.
- thresh change takes effect on the next mwi_valid evaluation.
- din is ignored when din_valid is low.

## Test plan
- Reset: assert rst mid-stream (state ABOVE) -> all outputs 0 asynchronously; after release, first din_valid yields mwi_valid 3 cycles later with index 0.
- Saturation: din=+100000, then -100000, then 4 zeros, continuous valid, MWI_LEN=32 -> internal x = 32767 then -32768; first d=(65534)>>>3=8191, mwi_out=8191^2>>5=2096640.
- Step: 100 zeros then constant 800, thresh=5000, step at index n0 -> mwi_out at n0..n0+3 = 1250, 4062, 6875, 8125. Then a single qrs_valid with qrs_peak=8125, qrs_idx=n0+3, raised after the MWI for n0+33 (4062).
- Refractory: second step from 800 to 1600 at 20 samples after detection -> no qrs_valid. Repeat at 60 samples after detection -> qrs_valid.
- Timeout: ramp x=100n, thresh=5000 -> steady mwi_out=15625. Forced qrs_valid after 64 ABOVE samples with qrs_peak=15625; then REFRACT; detections repeat every 64+50 MWI samples plus re-entry.
- Gaps: same step stimulus with din_valid asserted every 3rd cycle -> identical mwi_out sequence and qrs results; qrs_valid still exactly one cycle wide.
